// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one D-cache port between loads and committed stores, stores first with load anti-starvation.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ld_req,
  input  logic [31:0] i_ld_addr,
  input  logic [2:0]  i_ld_size,
  output logic        o_ld_grant,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  input  logic        i_st_req,
  input  logic [31:0] i_st_addr,
  input  logic [2:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic        o_st_grant,
  output logic        o_st_done,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [2:0]  o_mem_size,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_timeout_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_starve;
  logic [31:0] r_ld_data, r_mem_addr, r_mem_wdata;
  logic [2:0] r_mem_size;
  logic r_drop, r_mem_we, r_ld_valid, r_st_done;
  logic w_idle, w_ld_ok, w_force, w_st_gnt, w_ld_gnt, w_ld_ret, w_tmo;
  assign w_idle   = r_state == IDLE;
  assign w_ld_ok  = i_ld_req && !i_flush;
  assign w_force  = w_ld_ok && r_starve == SW'(STARVE_LIMIT);
  assign w_st_gnt = w_idle && i_st_req && !w_force;
  assign w_ld_gnt = w_idle && w_ld_ok && !w_st_gnt;
  // a squash seen at any point of the load, including its ack cycle, kills the response
  assign w_ld_ret = r_state == LOAD_WAIT && i_mem_ack && !r_drop && !i_flush;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wcnt;
  logic r_err;
  assign w_tmo = !w_idle && !i_mem_ack && r_wcnt == TW'(TIMEOUT_CYC - 1);
  assign o_timeout_err = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= w_idle ? '0 : r_wcnt + 1'b1;
      r_err  <= r_err | w_tmo;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign o_timeout_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_next = w_idle ? (w_ld_gnt ? LOAD_WAIT : w_st_gnt ? STORE_WAIT : IDLE)
                    : ((i_mem_ack || w_tmo) ? IDLE : r_state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_drop      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_size  <= '0;
      r_mem_wdata <= '0;
      r_ld_valid  <= 1'b0;
      r_ld_data   <= '0;
      r_st_done   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_starve   <= (!i_ld_req || w_ld_gnt) ? '0 :
                    (w_st_gnt && r_starve != SW'(STARVE_LIMIT)) ? r_starve + 1'b1 : r_starve;
      r_drop     <= r_state == LOAD_WAIT && w_next == LOAD_WAIT && (r_drop || i_flush);
      r_ld_valid <= w_ld_ret;
      r_ld_data  <= w_ld_ret ? i_mem_rdata : '0;
      r_st_done  <= r_state == STORE_WAIT && i_mem_ack;
      if (w_ld_gnt || w_st_gnt) begin
        r_mem_we    <= w_st_gnt;
        r_mem_addr  <= w_st_gnt ? i_st_addr : i_ld_addr;
        r_mem_size  <= w_st_gnt ? i_st_size : i_ld_size;
        r_mem_wdata <= w_st_gnt ? i_st_data : '0;
      end
    end
  end
  assign o_ld_grant  = w_ld_gnt;
  assign o_st_grant  = w_st_gnt;
  assign o_ld_valid  = r_ld_valid;
  assign o_ld_data   = r_ld_data;
  assign o_st_done   = r_st_done;
  assign o_mem_req   = !w_idle;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_size  = r_mem_size;
  assign o_mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port data-cache controller that shares one cache port between the load buffer (read requests) and the store queue commit path (write requests). Allows one outstanding transaction at a time and sequences it with a three-state FSM. Gives committed stores priority, with a starvation counter that guarantees load forward progress. Sits between the load buffer / store queue and the D-cache interface.

## Interface
- STARVE_LIMIT, 4: consecutive store grants while a load waits before the load is forced to win.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only with the configuration macro.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_req  in  1  load buffer has a request; held until ld_grant.
- ld_addr  in  32  load address.
- ld_size  in  3  load memory size code.
- ld_grant  out  1  combinational one-cycle accept of the load request.
- ld_valid  out  1  registered one-cycle pulse: load data returned.
- ld_data  out  32  load data; valid with ld_valid, 0 otherwise.
- st_req  in  1  store queue has a committed store; held until st_grant.
- st_addr  in  32  store address.
- st_size  in  3  store size code.
- st_data  in  32  store data.
- st_grant  out  1  combinational one-cycle accept of the store request.
- st_done  out  1  registered one-cycle pulse: store written.
- flush  in  1  squash; drops any pending load response.
- mem_req  out  1  request to cache; held high until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  registered address.
- mem_size  out  3  registered size.
- mem_wdata  out  32  registered write data; 0 for reads.
- mem_ack  in  1  cache completes the transaction this cycle.
- mem_rdata  in  32  read data; valid with mem_ack.
- timeout_err  out  1  sticky watchdog error flag.

## Operation
- States: IDLE, LOAD_WAIT, STORE_WAIT. On reset: state IDLE; starve_cnt 0; all outputs 0.
- IDLE arbitration, evaluated combinationally:
  - If starve_cnt == STARVE_LIMIT and ld_req and !flush: grant the load.
  - Otherwise, if st_req: grant the store.
  - Otherwise, if ld_req and !flush: grant the load.
  - Otherwise: no grant.
- On grant, latch address, size, data and direction into the mem_* registers. Next state is LOAD_WAIT or STORE_WAIT.
- Grants only ever occur in IDLE. ld_grant and st_grant are never high together.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, on a store grant while ld_req is high.
  - Clears on a load grant, or in any cycle where ld_req is low.
- WAIT states: mem_req=1 with stable mem_* outputs.
  - On mem_ack, next state is IDLE and mem_req drops next cycle.
  - LOAD_WAIT + mem_ack: ld_data <= mem_rdata, ld_valid <= 1, unless the load is squashed.
  - STORE_WAIT + mem_ack: st_done <= 1.
- Squash rule: flush during LOAD_WAIT, including the ack cycle, sets a drop flag. The cache transaction still completes, but ld_valid is suppressed. The drop flag clears on return to IDLE.
- flush has no effect on stores.
- mem_ack in IDLE is ignored.
- Reset asserted mid-transaction returns immediately to IDLE. No pulse is emitted and mem_req drops asynchronously.

## Timing
- Request in cycle 0: grant in cycle 0; mem_req high from cycle 1.
- mem_ack in cycle k≥1: ld_valid/st_done in cycle k+1; state IDLE in cycle k+1.
- A new grant is possible in cycle k+1, so the minimum back-to-back spacing is 2 cycles.
- Best-case load latency, request to ld_valid: 2 cycles.
- ld_valid/st_done are single-cycle pulses; ld_data returns to 0 the following cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A wait counter clears on entry to either WAIT state and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYC without mem_ack: timeout_err is set (sticky until reset), state returns to IDLE, and no ld_valid/st_done is emitted.
- MEM_ARB_TIMEOUT_EN undefined: no counter; timeout_err tied 0; WAIT states persist indefinitely.

## Test plan
- Load only: ld_req, addr 0x100, cycle 0; mem_ack with rdata 0xDEADBEEF in cycle 3 -> ld_grant in cycle 0; mem_req, mem_we=0 in cycles 1-3; ld_valid with ld_data=0xDEADBEEF in cycle 4 only.
- Simultaneous ld_req and st_req, ack 1 cycle after each mem_req -> store granted first; load granted in the cycle after st_done-state IDLE; no overlap of mem_req transactions.
- Starvation: ld_req held with st_req continuously high, STARVE_LIMIT=4 -> exactly 4 stores granted, then the 5th grant goes to the load, then starve_cnt returns to 0.
- Flush during LOAD_WAIT, cycle 2; ack in cycle 4 -> mem_req still held until the ack; ld_valid stays 0; the next load completes normally.
- reset_n low during STORE_WAIT -> all outputs 0 immediately; no st_done; a request after release is granted normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> timeout_err=1 after 8 WAIT cycles; FSM returns to IDLE; the flag stays set until reset.
